// File: rtl/tick_timer_pkg.sv
// -----------------------------------------------------------------------------
// tick_timer_pkg
// Types and constants shared by the BCD countdown timer:
//   state_e   - 2-bit FSM state enumeration (IDLE, RUN, PAUSE, DONE)
//   BCD_W     - width of one BCD digit
//   BCD_MAX   - largest legal BCD digit value
//   bcd_sat() - clamps a nibble to a legal BCD digit
// -----------------------------------------------------------------------------
package tick_timer_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Nibbles A..F are not BCD; treat them as the largest digit.
  function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/tick_timer_if.sv
// -----------------------------------------------------------------------------
// tick_timer_if
// Control/status bundle of the tick timer (clock and reset stay plain ports).
//   tick      - one-cycle enable pulse from the upstream divider
//   clear     - synchronous clear request
//   load      - load request, load_val is the packed BCD value
//   start     - run request
//   pause     - hold request
//   bcd_out   - registered packed BCD count
//   running   - high while the timer is counting
//   done      - one-cycle pulse when the count expires
// Modports: master drives the requests, slave (the timer) drives the status.
// -----------------------------------------------------------------------------
interface tick_timer_if
  import tick_timer_pkg::*;
#(
  parameter int DIGITS = 2
);

  logic                    tick;
  logic                    clear;
  logic                    load;
  logic [BCD_W*DIGITS-1:0] load_val;
  logic                    start;
  logic                    pause;
  logic [BCD_W*DIGITS-1:0] bcd_out;
  logic                    running;
  logic                    done;

  modport master (
    output tick, clear, load, load_val, start, pause,
    input  bcd_out, running, done
  );

  modport slave (
    input  tick, clear, load, load_val, start, pause,
    output bcd_out, running, done
  );

endinterface

// File: rtl/tick_timer_bcd_dec_digit.sv
// -----------------------------------------------------------------------------
// bcd_dec_digit
// One registered BCD digit of a down counter.
//   org_clk, rst_n - clock, asynchronous active-low reset
//   clear_i        - force digit to 0 (highest priority)
//   load_i         - load load_digit_i, saturated to 9
//   load_digit_i   - digit value to load
//   dec_i          - decrement enable for the whole counter
//   borrow_i       - borrow from the less significant digit (1 for digit 0)
//   digit_o        - registered digit value
//   borrow_o       - borrow to the more significant digit
// -----------------------------------------------------------------------------
module bcd_dec_digit
  import tick_timer_pkg::*;
(
  input  logic             org_clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_digit_i,
  input  logic             dec_i,
  input  logic             borrow_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             borrow_o
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  // Borrow ripples through every digit that is already zero, so the borrow
  // out of the top digit doubles as an "entire count is zero" flag.
  assign borrow_o = borrow_i && (digit_q == '0);

  always_comb begin
    digit_d = digit_q;
    if (clear_i) begin
      digit_d = '0;
    end else if (load_i) begin
      digit_d = bcd_sat(load_digit_i);
    end else if (dec_i && borrow_i) begin
      digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 1'b1;
    end
  end

  always_ff @(posedge org_clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;

endmodule

// File: rtl/tick_timer.sv
// -----------------------------------------------------------------------------
// tick_timer
// Loadable BCD countdown timer advanced by an external tick pulse.
//   org_clk - single clock
//   rst_n   - asynchronous active-low reset
//   bus     - tick_timer_if.slave: tick/clear/load/load_val/start/pause in,
//             bcd_out/running/done out
// Parameter DIGITS (1..4) sets the number of BCD digits.
// Request priority within a cycle: clear > load > pause > start > tick.
// Build option: define TICK_TIMER_AUTORELOAD_EN to keep the last accepted
// load value in a reload register and restart from it whenever the count
// expires (done still pulses; DONE is entered only for a zero reload value).
// -----------------------------------------------------------------------------
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int DIGITS = 2
)(
  input  logic org_clk,
  input  logic rst_n,
  tick_timer_if.slave bus
);

  localparam int W = BCD_W * DIGITS;
  localparam logic [W-1:0] COUNT_ONE = W'(1);

  state_e         state_q, state_d;
  logic           done_q, done_d;

  logic           dig_clear;
  logic           dig_load;
  logic           dig_dec;
  logic [W-1:0]   load_src;
  logic [W-1:0]   count_q;
  logic [DIGITS:0] borrow;
  logic           count_zero;
  logic           count_one;

`ifdef TICK_TIMER_AUTORELOAD_EN
  logic [W-1:0]   reload_q, reload_d;
  logic [W-1:0]   load_sat;
`endif

  // ---------------------------------------------------------------------------
  // Digit chain: digit 0 always sees a borrow, so a decrement always hits it.
  // ---------------------------------------------------------------------------
  assign borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_dec_digit u_digit (
        .org_clk      (org_clk),
        .rst_n        (rst_n),
        .clear_i      (dig_clear),
        .load_i       (dig_load),
        .load_digit_i (load_src[gi*BCD_W +: BCD_W]),
        .dec_i        (dig_dec),
        .borrow_i     (borrow[gi]),
        .digit_o      (count_q[gi*BCD_W +: BCD_W]),
        .borrow_o     (borrow[gi+1])
      );
`ifdef TICK_TIMER_AUTORELOAD_EN
      // The reload register keeps the value the counter actually loaded.
      assign load_sat[gi*BCD_W +: BCD_W] = bcd_sat(bus.load_val[gi*BCD_W +: BCD_W]);
`endif
    end
  endgenerate

  assign count_zero = borrow[DIGITS];
  assign count_one  = (count_q == COUNT_ONE);

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    dig_clear = 1'b0;
    dig_load  = 1'b0;
    dig_dec   = 1'b0;
    load_src  = bus.load_val;
`ifdef TICK_TIMER_AUTORELOAD_EN
    reload_d  = reload_q;
`endif

    if (bus.clear) begin
      dig_clear = 1'b1;
      state_d   = ST_IDLE;
    end else if (bus.load && (state_q != ST_RUN)) begin
      dig_load  = 1'b1;
      state_d   = ST_IDLE;
`ifdef TICK_TIMER_AUTORELOAD_EN
      reload_d  = load_sat;
`endif
    end else begin
      // A load during RUN is dropped and the lower-priority requests apply.
      unique case (state_q)
        ST_IDLE, ST_PAUSE: begin
          if (!bus.pause && bus.start && !count_zero) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.pause) begin
            state_d = ST_PAUSE;
          end else if (bus.tick) begin
            if (count_one) begin
              done_d = 1'b1;
`ifdef TICK_TIMER_AUTORELOAD_EN
              dig_load = 1'b1;
              load_src = reload_q;
              state_d  = (reload_q == '0) ? ST_DONE : ST_RUN;
`else
              dig_dec = 1'b1;
              state_d = ST_DONE;
`endif
            end else begin
              dig_dec = 1'b1;
            end
          end
        end
        ST_DONE: begin
          // Only clear or load (handled above) leave DONE.
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge org_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

`ifdef TICK_TIMER_AUTORELOAD_EN
  always_ff @(posedge org_clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  // All outputs come straight from registers.
  assign bus.bcd_out = count_q;
  assign bus.running = (state_q == ST_RUN);
  assign bus.done    = done_q;

endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 The module SHALL have parameter DIGITS, default 2, meaning the number of BCD digits in the count; legal range is 1..4.
REQ-002 The module SHALL have port org_clk, input, 1 bit: the single clock.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port tick, input, 1 bit: a one-cycle enable pulse from the upstream frequency divider, synchronous to org_clk.
REQ-005 The module SHALL have port clear, input, 1 bit: synchronous clear.
REQ-006 The module SHALL have port load, input, 1 bit: load request.
REQ-007 The module SHALL have port load_val, input, 4*DIGITS bits: packed BCD value to load.
REQ-008 The module SHALL have ports start and pause, each input, 1 bit: run and hold requests.
REQ-009 The module SHALL have port bcd_out, output, 4*DIGITS bits: the current registered count.
REQ-010 The module SHALL have port running, output, 1 bit: high while the state is RUN.
REQ-011 The module SHALL have port done, output, 1 bit: a one-cycle pulse when the count expires.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN, PAUSE and DONE, with every transition taken on a rising edge of org_clk.
REQ-013 Request priority SHALL be, in each cycle: clear > load > pause > start > tick.
REQ-014 clear SHALL force the count to 0 and the state to IDLE from any state.
REQ-015 load SHALL copy load_val into the count and enter IDLE when the state is IDLE, PAUSE or DONE; load SHALL be ignored in RUN.
REQ-016 When loading, any load_val digit greater than 9 SHALL be saturated to 9.
REQ-017 In IDLE or PAUSE, start with a nonzero count SHALL enter RUN; start with a zero count SHALL be ignored.
REQ-018 In RUN, pause SHALL enter PAUSE; when pause and tick are high in the same cycle, pause wins and the count is not decremented.
REQ-019 In RUN, tick SHALL decrement the count by 1 in BCD, with a borrow that sets a digit from 0 to 9 and decrements the next digit (for example 10 -> 09, 100 -> 099).
REQ-020 In RUN, a tick when the count is 1 SHALL set the count to 0 and enter DONE (non-reload build).
REQ-021 done SHALL be high for exactly the one cycle after the edge on which the count reaches 0; it SHALL never be high for two consecutive cycles.
REQ-022 In DONE, the count SHALL hold 0, tick, start and pause SHALL be ignored, and only load or clear SHALL leave the state.
REQ-023 tick SHALL be ignored in IDLE, PAUSE and DONE.
REQ-024 bcd_out SHALL reflect a new count one cycle after the edge on which tick, load or clear is sampled, and SHALL be driven from registers with no combinational path from inputs.

Reset
REQ-025 While rst_n is low, the state SHALL be IDLE, bcd_out SHALL be 0, running SHALL be 0, done SHALL be 0, and the reload register SHALL be 0.
REQ-026 A reset asserted during RUN SHALL abort the countdown immediately, with no done pulse.
REQ-027 After rst_n deasserts, start SHALL be ignored until a nonzero value is loaded.

Configuration
REQ-028 With macro TICK_TIMER_AUTORELOAD_EN defined, the module SHALL capture each accepted load value into a reload register.
REQ-029 With TICK_TIMER_AUTORELOAD_EN defined, a tick at count 1 in RUN SHALL reload the count from the reload register, stay in RUN, and still pulse done; DONE SHALL then be entered only if the reload value is 0.
REQ-030 With TICK_TIMER_AUTORELOAD_EN undefined, the reload register SHALL not exist and the behaviour SHALL be as in REQ-020.

Structure
REQ-031 The package tick_timer_pkg SHALL hold the state enumeration typedef (2 bits) and the BCD constants (digit maximum 9, digit width 4).
REQ-032 A sub-module bcd_dec_digit SHALL be used: one 4-bit BCD digit with borrow-in, borrow-out, load and saturation, instantiated DIGITS times in a generate loop.

Verification
REQ-033 Load 0x12, start, then 12 ticks -> bcd_out steps 12, 11, 10, 09, ..., 01, 00; done high one cycle; state DONE; running 0.
REQ-034 Load 0x05, start, 2 ticks, pause together with a tick -> bcd_out 03 and state PAUSE; 3 further ticks -> bcd_out stays 03; start then 3 ticks -> done.
REQ-035 Load 0xA7 -> bcd_out 97; start with count 00 after clear -> state stays IDLE and running stays 0.
REQ-036 With TICK_TIMER_AUTORELOAD_EN defined, load 0x02, start, 6 ticks -> 01, 00->02 reload, ...; done pulses 3 times; running stays 1.
REQ-037 Drive rst_n low mid-RUN at count 07 -> bcd_out 00, state IDLE and done 0 asynchronously; clear asserted together with load 0x50 -> count 00.
